booth_sequencer: RTL and testbench
==================================

// Module: booth_sequencer
// PURPOSE
//  Control stage directly upstream of the 8-bit Booth multiplier datapath (booth).
//  Accepts an operand pair on a valid/ready handshake and drives booth's 3-bit enable code and inbus.
//  Steps booth through INITIALIZE, LOAD_Q, LOAD_M, RUN x8, STORE_A and STORE_Q.
//  Collects A:Q from booth's outbus and presents the signed 16-bit product on a valid/ready output.
// PARAMETERS
//  WIDTH       8   operand width; must equal the booth datapath width
//  RUN_CYCLES  8   cycles RUN is held; equals WIDTH; booth's internal count caps at 8 iterations
// PORTS
//  clk              in   1        single clock; all state updates on rising edge
//  rst              in   1        asynchronous, active-high reset
//  in_valid         in   1        operand pair valid
//  in_ready         out  1        sequencer can accept an operand pair
//  in_multiplicand  in   WIDTH    M operand, two's complement
//  in_multiplier    in   WIDTH    Q operand, two's complement
//  out_valid        out  1        product valid
//  out_ready        in   1        consumer accepts product
//  out_product      out  2*WIDTH  signed product {A,Q}
//  booth_enable     out  3        enable code to booth
//  booth_inbus      out  WIDTH    operand bus to booth
//  booth_outbus     in   WIDTH    result bus from booth
//  busy             out  1        high in every state except IDLE
// BEHAVIOUR
//  Reset values (async assert): state=IDLE, booth_enable=3'b000 (NOP; booth takes no action),
//   booth_inbus=0, out_product=0, out_valid=0, in_ready=1, busy=0. Registered outputs only.
//  Enable codes: NOP 000, INITIALIZE 001, LOAD_Q 010, LOAD_M 011, RUN 100, STORE_A 101, STORE_Q 110.
//  FSM, one state per cycle unless noted:
//   IDLE : in_ready=1. On in_valid&in_ready, latch both operands and go to INIT.
//   INIT : enable=INITIALIZE -> LDQ.
//   LDQ  : enable=LOAD_Q, inbus=multiplier -> LDM.
//   LDM  : enable=LOAD_M, inbus=multiplicand -> RUN.
//   RUN  : enable=RUN for exactly RUN_CYCLES cycles; a 4-bit run counter counts 0..RUN_CYCLES-1 -> STA.
//   STA  : enable=STORE_A -> STQ.
//   STQ  : enable=STORE_Q; capture booth_outbus (A) into product[15:8] -> CAPQ.
//   CAPQ : enable=NOP; capture booth_outbus (Q) into product[7:0] -> DONE.
//   DONE : out_valid=1, out_product stable. On out_ready, go to IDLE and drop out_valid next cycle.
//  inbus is 0 outside LDQ and LDM. Enable is NOP in IDLE and DONE.
//  Latency: handshake in cycle 0 -> out_valid high in cycle 7+RUN_CYCLES (15 at default).
//  Throughput: one product per 8+RUN_CYCLES cycles when out_ready is held high.
//  in_ready is 0 in every non-IDLE state. in_valid there is ignored; operands are not re-latched.
//  Back-pressure: DONE holds indefinitely while out_ready=0; product and out_valid do not change.
//  out_valid and in_ready are never high together. A new operand cannot be taken in the DONE-exit cycle.
//  Reset during any state, including mid-RUN: immediate return to IDLE with reset values.
//   A partial product is never emitted. The next operation re-issues INITIALIZE.
//  Arithmetic: no width changes in the sequencer; the product is the raw booth {A,Q}, so -128*-128=+16384.
// STRUCTURE
//  Shared package booth_pkg: enable-code localparams (NOP..STORE_Q), FSM state encoding,
//   WIDTH/RUN_CYCLES defaults. booth and booth_sequencer both import it.
//  No sub-module; single FSM with an operand register, run counter and product register.
//  Integration top booth_unit instantiates booth_sequencer + booth (outside this file).
// TESTING (bench instantiates booth_sequencer + booth)
//  1 M=3, Q=5, out_ready=1 -> out_product=16'h000F, out_valid in cycle 15 after handshake.
//  2 M=-128, Q=-128 -> 16'h4000. M=-1, Q=1 -> 16'hFFFF. M=127, Q=-128 -> 16'hC080.
//  3 Enable trace for one op: 001,010,011,100 x8,101,110,000 exact; inbus=Q in LDQ, M in LDM, else 0.
//  4 out_ready=0 for 20 cycles in DONE -> product/out_valid stable, in_ready=0; release -> IDLE, accept next.
//  5 in_valid held high with changing operands during an op -> ignored; result matches latched pair.
//  6 rst asserted in RUN cycle 4 -> IDLE same edge, out_valid stays 0; next op 7*9 -> 16'h003F.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier datapath and its sequencer:
// enable codes, sequencer state encoding and default sizing.
package booth_pkg;

  localparam int unsigned DEFAULT_WIDTH      = 8;
  localparam int unsigned DEFAULT_RUN_CYCLES = 8;

  localparam logic [2:0] ENABLE_NOP        = 3'b000;
  localparam logic [2:0] ENABLE_INITIALIZE = 3'b001;
  localparam logic [2:0] ENABLE_LOAD_Q     = 3'b010;
  localparam logic [2:0] ENABLE_LOAD_M     = 3'b011;
  localparam logic [2:0] ENABLE_RUN        = 3'b100;
  localparam logic [2:0] ENABLE_STORE_A    = 3'b101;
  localparam logic [2:0] ENABLE_STORE_Q    = 3'b110;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_LDQ,
    S_LDM,
    S_RUN,
    S_STA,
    S_STQ,
    S_CAPQ,
    S_DONE
  } seq_state_t;

  function automatic logic [2:0] enable_for(input seq_state_t s);
    logic [2:0] code;
    code = ENABLE_NOP;
    case (s)
      S_INIT:  code = ENABLE_INITIALIZE;
      S_LDQ:   code = ENABLE_LOAD_Q;
      S_LDM:   code = ENABLE_LOAD_M;
      S_RUN:   code = ENABLE_RUN;
      S_STA:   code = ENABLE_STORE_A;
      S_STQ:   code = ENABLE_STORE_Q;
      default: code = ENABLE_NOP;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/booth_sequencer.sv
// Control stage for the Booth datapath: takes an operand pair, walks booth through
// INITIALIZE/LOAD/RUN/STORE and returns the {A,Q} product on a valid/ready output.
module booth_sequencer
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter int unsigned RUN_CYCLES = DEFAULT_RUN_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_multiplicand,
  input  logic [WIDTH-1:0]   in_multiplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic [2:0]         booth_enable,
  output logic [WIDTH-1:0]   booth_inbus,
  input  logic [WIDTH-1:0]   booth_outbus,
  output logic               busy
);

  localparam logic [3:0] RUN_LAST = 4'(RUN_CYCLES - 1);

  seq_state_t       state;
  seq_state_t       next_state;
  logic             accept;
  logic [WIDTH-1:0] op_m;
  logic [WIDTH-1:0] op_q;
  logic [3:0]       run_cnt;

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          accept     = 1'b1;
          next_state = S_INIT;
        end
      end
      S_INIT:  next_state = S_LDQ;
      S_LDQ:   next_state = S_LDM;
      S_LDM:   next_state = S_RUN;
      S_RUN:   if (run_cnt == RUN_LAST) next_state = S_STA;
      S_STA:   next_state = S_STQ;
      S_STQ:   next_state = S_CAPQ;
      S_CAPQ:  next_state = S_DONE;
      S_DONE:  if (out_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Outputs are registered from next_state so each one lines up with the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_m         <= '0;
      op_q         <= '0;
      run_cnt      <= '0;
      out_product  <= '0;
      booth_enable <= ENABLE_NOP;
      booth_inbus  <= '0;
      out_valid    <= 1'b0;
      in_ready     <= 1'b1;
      busy         <= 1'b0;
    end else begin
      if (accept) begin
        op_m <= in_multiplicand;
        op_q <= in_multiplier;
      end
      run_cnt <= (state == S_RUN) ? run_cnt + 4'd1 : '0;
      if (state == S_STQ)  out_product[2*WIDTH-1:WIDTH] <= booth_outbus;
      if (state == S_CAPQ) out_product[WIDTH-1:0]       <= booth_outbus;
      booth_enable <= enable_for(next_state);
      booth_inbus  <= (next_state == S_LDQ) ? op_q :
                      (next_state == S_LDM) ? op_m : '0;
      out_valid    <= (next_state == S_DONE);
      in_ready     <= (next_state == S_IDLE);
      busy         <= (next_state != S_IDLE);
    end
  end

endmodule

// File: tb/tb_booth_sequencer.sv
// Directed bench for booth_sequencer driving a behavioural 8-bit Booth datapath.
module tb_booth_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_multiplicand;
  logic [7:0]  in_multiplier;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_product;
  logic [2:0]  booth_enable;
  logic [7:0]  booth_inbus;
  logic [7:0]  booth_outbus;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_sequencer #(.WIDTH(8), .RUN_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_multiplicand(in_multiplicand), .in_multiplier(in_multiplier),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .booth_enable(booth_enable), .booth_inbus(booth_inbus),
    .booth_outbus(booth_outbus), .busy(busy)
  );

  // Behavioural Booth datapath; 9-bit accumulator so -128*-128 does not overflow.
  logic signed [8:0] b_a;
  logic signed [8:0] b_sum;
  logic [7:0]        b_q;
  logic [7:0]        b_m;
  logic              b_q1;
  logic [3:0]        b_cnt;

  always_comb begin
    b_sum = b_a;
    case ({b_q[0], b_q1})
      2'b01:   b_sum = b_a + {b_m[7], b_m};
      2'b10:   b_sum = b_a - {b_m[7], b_m};
      default: b_sum = b_a;
    endcase
  end

  always @(posedge clk) begin
    case (booth_enable)
      3'b001: begin b_a <= '0; b_q1 <= 1'b0; b_cnt <= '0; end
      3'b010: b_q <= booth_inbus;
      3'b011: b_m <= booth_inbus;
      3'b100: if (b_cnt < 4'd8) begin
        b_a   <= {b_sum[8], b_sum[8:1]};
        b_q   <= {b_sum[0], b_q[7:1]};
        b_q1  <= b_q[0];
        b_cnt <= b_cnt + 4'd1;
      end
      3'b101: booth_outbus <= b_a[7:0];
      3'b110: booth_outbus <= b_q;
      default: ;
    endcase
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_en(input int k);
    if (k == 1)             return 3'b001;
    if (k == 2)             return 3'b010;
    if (k == 3)             return 3'b011;
    if (k >= 4 && k <= 11)  return 3'b100;
    if (k == 12)            return 3'b101;
    if (k == 13)            return 3'b110;
    return 3'b000;
  endfunction

  // Handshake in the current IDLE cycle, trace every cycle up to DONE, check product.
  task automatic run_op(input string tag, input logic [7:0] m, input logic [7:0] q,
                        input logic [15:0] exp, input bit noisy);
    int k;
    chk($sformatf("%s idle_ready", tag), 32'(in_ready), 1);
    in_valid        = 1'b1;
    in_multiplicand = m;
    in_multiplier   = q;
    tick();
    in_valid = noisy;
    k = 1;
    while (!out_valid && k < 40) begin
      chk($sformatf("%s enable k=%0d", tag, k), 32'(booth_enable), 32'(exp_en(k)));
      chk($sformatf("%s inbus k=%0d", tag, k), 32'(booth_inbus),
          32'((k == 2) ? q : (k == 3) ? m : 8'h00));
      chk($sformatf("%s in_ready k=%0d", tag, k), 32'(in_ready), 0);
      chk($sformatf("%s busy k=%0d", tag, k), 32'(busy), 1);
      if (noisy) begin
        in_multiplicand = 8'($urandom);
        in_multiplier   = 8'($urandom);
      end
      tick();
      k++;
    end
    in_valid = 1'b0;
    chk($sformatf("%s latency", tag), 32'(k), 15);
    chk($sformatf("%s product", tag), 32'(out_product), 32'(exp));
    chk($sformatf("%s done_enable", tag), 32'(booth_enable), 0);
    chk($sformatf("%s done_in_ready", tag), 32'(in_ready), 0);
  endtask

  task automatic finish_op(input string tag);
    tick();
    chk($sformatf("%s exit_valid", tag), 32'(out_valid), 0);
    chk($sformatf("%s exit_ready", tag), 32'(in_ready), 1);
    chk($sformatf("%s exit_busy", tag), 32'(busy), 0);
  endtask

  initial begin
    rst             = 1'b1;
    in_valid        = 1'b0;
    in_multiplicand = '0;
    in_multiplier   = '0;
    out_ready       = 1'b1;
    #1;
    chk("rst enable", 32'(booth_enable), 0);
    chk("rst inbus", 32'(booth_inbus), 0);
    chk("rst product", 32'(out_product), 0);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst in_ready", 32'(in_ready), 1);
    chk("rst busy", 32'(busy), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    run_op("m3q5", 8'd3, 8'd5, 16'h000F, 1'b0);
    finish_op("m3q5");
    run_op("m128q128", 8'h80, 8'h80, 16'h4000, 1'b0);
    finish_op("m128q128");
    run_op("mneg1q1", 8'hFF, 8'h01, 16'hFFFF, 1'b0);
    finish_op("mneg1q1");
    run_op("m127q128", 8'h7F, 8'h80, 16'hC080, 1'b0);
    finish_op("m127q128");

    // Back-pressure: hold DONE with out_ready low while new operands are offered.
    out_ready = 1'b0;
    run_op("bp", 8'd5, 8'd6, 16'h001E, 1'b0);
    for (int i = 0; i < 20; i++) begin
      in_valid        = 1'b1;
      in_multiplicand = 8'(i + 40);
      in_multiplier   = 8'(i + 1);
      tick();
      chk($sformatf("bp hold_valid %0d", i), 32'(out_valid), 1);
      chk($sformatf("bp hold_product %0d", i), 32'(out_product), 32'h001E);
      chk($sformatf("bp hold_ready %0d", i), 32'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    finish_op("bp");

    run_op("noisy", 8'hFD, 8'h04, 16'hFFF4, 1'b1);
    finish_op("noisy");

    // Reset in the fourth RUN cycle.
    in_valid        = 1'b1;
    in_multiplicand = 8'd5;
    in_multiplier   = 8'd5;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    chk("mid pre_rst enable", 32'(booth_enable), 32'(3'b100));
    rst = 1'b1;
    #1;
    chk("mid rst enable", 32'(booth_enable), 0);
    chk("mid rst busy", 32'(busy), 0);
    chk("mid rst in_ready", 32'(in_ready), 1);
    chk("mid rst out_valid", 32'(out_valid), 0);
    chk("mid rst product", 32'(out_product), 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("mid quiet_valid %0d", i), 32'(out_valid), 0);
      chk($sformatf("mid quiet_enable %0d", i), 32'(booth_enable), 0);
    end
    run_op("m7q9", 8'd7, 8'd9, 16'h003F, 1'b0);
    finish_op("m7q9");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
